// File: rtl/banco_registradores_pkg.sv
// Shared definitions for the register bank.
// Holds the clear-sequencer state encoding and the address-width helper
// used to size every address bus from DEPTH.
package banco_registradores_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } clr_state_t;

  // Ceiling log2; never returns less than 1 so a 2-entry bank still has an
  // address bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/banco_registradores_if.sv
// Bus interface of the register bank.
// master: drives write port (we/waddr/wdata), shared read enable (re),
//         read addresses (raddr_a/raddr_b) and the clear request.
// slave : returns registered read data q_a/q_b, their valid flags and busy.
interface banco_registradores_if
  import banco_registradores_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int AW = clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             re;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic             clear;
  logic [WIDTH-1:0] q_a;
  logic [WIDTH-1:0] q_b;
  logic             valid_a;
  logic             valid_b;
  logic             busy;

  modport master (
    output we, waddr, wdata, re, raddr_a, raddr_b, clear,
    input  q_a, q_b, valid_a, valid_b, busy
  );

  modport slave (
    input  we, waddr, wdata, re, raddr_a, raddr_b, clear,
    output q_a, q_b, valid_a, valid_b, busy
  );

endinterface

// File: rtl/banco_registradores_clear_seq.sv
// Clear sequencer for the register bank.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   clear       : one-cycle request to wipe every entry (ignored while busy)
//   busy        : high for exactly DEPTH cycles while the sweep runs
//   sweep_en    : storage should zero entry[sweep_addr] on this edge
//   sweep_addr  : entry being zeroed
module banco_clear_seq
  import banco_registradores_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  output logic                    busy,
  output logic                    sweep_en,
  output logic [clog2(DEPTH)-1:0] sweep_addr
);
  localparam int AW = clog2(DEPTH);

  clr_state_t    r_state;
  clr_state_t    w_state_next;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_state_next = ST_SWEEP;
          w_cnt_next   = '0;
        end
      end
      ST_SWEEP: begin
        // Last entry zeroed on this edge; counter parks at 0 for the next run.
        if (r_cnt == AW'(DEPTH - 1)) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + AW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign busy       = (r_state == ST_SWEEP);
  assign sweep_en   = (r_state == ST_SWEEP);
  assign sweep_addr = r_cnt;

endmodule

// File: rtl/banco_registradores.sv
// Dual-read, single-write register bank with per-entry valid bit and a
// DEPTH-cycle clear sweep.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (clears everything)
//   bus        : banco_registradores_if slave modport (write port, shared
//                read enable, two read addresses, clear request; registered
//                read data + valid per port, busy)
module banco_registradores
  import banco_registradores_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  banco_registradores_if.slave  bus
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_data  [DEPTH];
  logic             r_valid [DEPTH];

  logic             w_busy;
  logic             w_sweep_en;
  logic [AW-1:0]    w_sweep_addr;
  logic             w_wr_ok;

  logic [WIDTH-1:0] w_mem_q_a;
  logic [WIDTH-1:0] w_mem_q_b;
  logic             w_mem_v_a;
  logic             w_mem_v_b;

  logic [WIDTH-1:0] r_q_a;
  logic [WIDTH-1:0] r_q_b;
  logic             r_valid_a;
  logic             r_valid_b;

  // Compare in 32 bits so the check stays meaningful when DEPTH is a power
  // of two and every AW-bit address is in range.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  banco_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clear      (bus.clear),
    .busy       (w_busy),
    .sweep_en   (w_sweep_en),
    .sweep_addr (w_sweep_addr)
  );

  // A clear request in the same cycle wins over the write.
  assign w_wr_ok = bus.we & ~w_busy & ~bus.clear & addr_ok(bus.waddr);

  // Storage update: sweep and accepted write are mutually exclusive because
  // writes are blocked while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]  <= '0;
        r_valid[i] <= 1'b0;
      end
    end else if (w_sweep_en) begin
      r_data[w_sweep_addr]  <= '0;
      r_valid[w_sweep_addr] <= 1'b0;
    end else if (w_wr_ok) begin
      r_data[bus.waddr]  <= bus.wdata;
      r_valid[bus.waddr] <= 1'b1;
    end
  end

  always_comb begin
    w_mem_q_a = '0;
    w_mem_v_a = 1'b0;
    w_mem_q_b = '0;
    w_mem_v_b = 1'b0;
    if (addr_ok(bus.raddr_a)) begin
      w_mem_q_a = r_data[bus.raddr_a];
      w_mem_v_a = r_valid[bus.raddr_a];
    end
    if (addr_ok(bus.raddr_b)) begin
      w_mem_q_b = r_data[bus.raddr_b];
      w_mem_v_b = r_valid[bus.raddr_b];
    end
  end

  // Read stage: one-cycle registered read with write-to-read bypass for
  // accepted writes only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_a     <= '0;
      r_q_b     <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end else if (bus.re) begin
      if (w_wr_ok && (bus.raddr_a == bus.waddr)) begin
        r_q_a     <= bus.wdata;
        r_valid_a <= 1'b1;
      end else begin
        r_q_a     <= w_mem_q_a;
        r_valid_a <= w_mem_v_a;
      end
      if (w_wr_ok && (bus.raddr_b == bus.waddr)) begin
        r_q_b     <= bus.wdata;
        r_valid_b <= 1'b1;
      end else begin
        r_q_b     <= w_mem_q_b;
        r_valid_b <= w_mem_v_b;
      end
    end
  end

  assign bus.q_a     = r_q_a;
  assign bus.q_b     = r_q_b;
  assign bus.valid_a = r_valid_a;
  assign bus.valid_b = r_valid_b;
  assign bus.busy    = w_busy;

endmodule

// File: tb/tb_banco_registradores.sv
module tb_banco_registradores;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  banco_registradores_if #(.WIDTH(4),  .DEPTH(8)) b8 ();
  banco_registradores_if #(.WIDTH(16), .DEPTH(6)) b6 ();

  banco_registradores #(.WIDTH(4), .DEPTH(8)) u8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8.slave)
  );

  banco_registradores #(.WIDTH(16), .DEPTH(6)) u6 (
    .clk   (clk),
    .reset (reset),
    .bus   (b6.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [3:0] wd;
    logic       re;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [3:0] eqa;
    logic       eva;
    logic [3:0] eqb;
    logic       evb;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv8(input logic we, input logic [2:0] wa, input logic [3:0] wd,
                      input logic re, input logic [2:0] ra, input logic [2:0] rb,
                      input logic clr);
    b8.we = we; b8.waddr = wa; b8.wdata = wd;
    b8.re = re; b8.raddr_a = ra; b8.raddr_b = rb; b8.clear = clr;
  endtask

  task automatic drv6(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      input logic re, input logic [2:0] ra, input logic [2:0] rb,
                      input logic clr);
    b6.we = we; b6.waddr = wa; b6.wdata = wd;
    b6.re = re; b6.raddr_a = ra; b6.raddr_b = rb; b6.clear = clr;
  endtask

  task automatic chk8(input string tag, input logic [3:0] qa, input logic va,
                      input logic [3:0] qb, input logic vb);
    chk({tag, "_qa"}, 32'(b8.q_a), 32'(qa));
    chk({tag, "_va"}, 32'(b8.valid_a), 32'(va));
    chk({tag, "_qb"}, 32'(b8.q_b), 32'(qb));
    chk({tag, "_vb"}, 32'(b8.valid_b), 32'(vb));
  endtask

  initial begin
    int nbusy;

    vecs[0] = '{1'b1, 3'd3, 4'hA, 1'b0, 3'd0, 3'd0, 4'h0, 1'b0, 4'h0, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd3, 3'd0, 4'hA, 1'b1, 4'h0, 1'b0};
    vecs[2] = '{1'b1, 3'd5, 4'h7, 1'b1, 3'd5, 3'd5, 4'h7, 1'b1, 4'h7, 1'b1};
    vecs[3] = '{1'b1, 3'd3, 4'hC, 1'b0, 3'd0, 3'd0, 4'h7, 1'b1, 4'h7, 1'b1};
    vecs[4] = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd3, 3'd5, 4'hC, 1'b1, 4'h7, 1'b1};
    vecs[5] = '{1'b1, 3'd0, 4'hF, 1'b1, 3'd0, 3'd3, 4'hF, 1'b1, 4'hC, 1'b1};
    vecs[6] = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd1, 3'd0, 4'h0, 1'b0, 4'hF, 1'b1};
    vecs[7] = '{1'b1, 3'd7, 4'h1, 1'b1, 3'd7, 3'd6, 4'h1, 1'b1, 4'h0, 1'b0};

    drv8(0, 0, 0, 0, 0, 0, 0);
    drv6(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk8("rst8", 4'h0, 1'b0, 4'h0, 1'b0);
    chk("rst8_busy", 32'(b8.busy), 32'd0);
    chk("rst6_qa", 32'(b6.q_a), 32'd0);
    chk("rst6_busy", 32'(b6.busy), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      drv8(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].rb, 1'b0);
      tick();
      chk8($sformatf("vec%0d", i), vecs[i].eqa, vecs[i].eva, vecs[i].eqb, vecs[i].evb);
    end

    // Fill all entries with i+1, then sweep.
    for (int i = 0; i < 8; i++) begin
      drv8(1, 3'(i), 4'(i + 1), 0, 0, 0, 0);
      tick();
    end
    drv8(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("clr_busy_pre", 32'(b8.busy), 32'd0);
    drv8(0, 0, 0, 0, 0, 0, 1);
    tick();
    drv8(0, 0, 0, 0, 0, 0, 0);
    nbusy = 0;
    for (int k = 0; k < 12; k++) begin
      if (b8.busy) nbusy++;
      if (k == 0) begin
        chk("clr_busy_rise", 32'(b8.busy), 32'd1);
        drv8(1, 3'd4, 4'h9, 1, 3'd7, 3'd7, 0);
      end
      if (k == 1) begin
        chk8("clr_partial7", 4'h8, 1'b1, 4'h8, 1'b1);
        drv8(1, 3'd4, 4'h9, 1, 3'd0, 3'd0, 0);
      end
      if (k == 2) begin
        chk8("clr_partial0", 4'h0, 1'b0, 4'h0, 1'b0);
        drv8(1, 3'd4, 4'h9, 0, 3'd0, 3'd0, 0);
      end
      if (k == 7) drv8(0, 0, 0, 0, 0, 0, 0);
      if (k == 8) chk("clr_busy_fall", 32'(b8.busy), 32'd0);
      tick();
    end
    chk("clr_busy_len", 32'(nbusy), 32'd8);
    for (int i = 0; i < 8; i += 2) begin
      drv8(0, 0, 0, 1, 3'(i), 3'(i + 1), 0);
      tick();
      chk8($sformatf("clr_rd%0d", i), 4'h0, 1'b0, 4'h0, 1'b0);
    end

    // Clear and write together: clear wins, no bypass of the dropped write.
    drv8(1, 3'd2, 4'h3, 0, 0, 0, 0);
    tick();
    drv8(1, 3'd2, 4'h5, 1, 3'd2, 3'd2, 1);
    tick();
    chk8("coll_nobyp", 4'h3, 1'b1, 4'h3, 1'b1);
    chk("coll_busy", 32'(b8.busy), 32'd1);
    drv8(0, 0, 0, 0, 0, 0, 0);
    repeat (10) tick();
    chk("coll_busy_done", 32'(b8.busy), 32'd0);
    drv8(0, 0, 0, 1, 3'd2, 3'd2, 0);
    tick();
    chk8("coll_rd2", 4'h0, 1'b0, 4'h0, 1'b0);

    // Reset in the middle of a sweep.
    drv8(1, 3'd6, 4'h6, 0, 0, 0, 0);
    tick();
    drv8(0, 0, 0, 1, 3'd6, 3'd6, 0);
    tick();
    chk8("mid_pre", 4'h6, 1'b1, 4'h6, 1'b1);
    drv8(0, 0, 0, 0, 0, 0, 1);
    tick();
    drv8(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("mid_busy", 32'(b8.busy), 32'd1);
    #2;
    reset = 1'b1;
    drv8(1, 3'd6, 4'hF, 1, 3'd6, 3'd6, 1);
    #1;
    chk("mid_rst_busy", 32'(b8.busy), 32'd0);
    chk8("mid_rst", 4'h0, 1'b0, 4'h0, 1'b0);
    tick();
    #2;
    drv8(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk("mid_idle", 32'(b8.busy), 32'd0);
    drv8(0, 0, 0, 1, 3'd6, 3'd6, 0);
    tick();
    chk8("mid_rd6", 4'h0, 1'b0, 4'h0, 1'b0);

    // DEPTH=6, WIDTH=16 instance.
    drv6(1, 3'd5, 16'h1234, 0, 0, 0, 0);
    tick();
    drv6(1, 3'd7, 16'hBEEF, 1, 3'd7, 3'd5, 0);
    tick();
    chk("d6_rd7_q", 32'(b6.q_a), 32'd0);
    chk("d6_rd7_v", 32'(b6.valid_a), 32'd0);
    chk("d6_rd5_q", 32'(b6.q_b), 32'h1234);
    chk("d6_rd5_v", 32'(b6.valid_b), 32'd1);
    drv6(0, 0, 0, 1, 3'd6, 3'd5, 0);
    tick();
    chk("d6_rd6_q", 32'(b6.q_a), 32'd0);
    chk("d6_rd6_v", 32'(b6.valid_a), 32'd0);
    chk("d6_rd5b_q", 32'(b6.q_b), 32'h1234);
    drv6(0, 0, 0, 0, 0, 0, 1);
    tick();
    drv6(0, 0, 0, 0, 0, 0, 0);
    nbusy = 0;
    for (int k = 0; k < 10; k++) begin
      if (b6.busy) nbusy++;
      tick();
    end
    chk("d6_busy_len", 32'(nbusy), 32'd6);
    drv6(0, 0, 0, 1, 3'd5, 3'd5, 0);
    tick();
    chk("d6_swept_q", 32'(b6.q_a), 32'd0);
    chk("d6_swept_v", 32'(b6.valid_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
